if_fetch_unit: RTL

Instruction-fetch stage that drives the PC seen by the branch target buffer and consumes its predicted next PC. It issues fetches to the instruction cache over a req/ready handshake and fills the IF/ID pipeline register. It applies redirects from the ID-stage flush codes, buffers one returned instruction when ID stalls, and discards a stale in-flight fetch after a flush.

---
 rtl/cpu_defs.sv | 17 +
 rtl/fetch_redirect_mux.sv | 27 ++
 rtl/if_fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared fetch-stage definitions: datapath width, ID flush codes, fetch FSM encoding.
package cpu_defs;
    localparam int WORD_SIZE       = 16;
    localparam int FLUSH_CODE_SIZE = 3;

    localparam logic [FLUSH_CODE_SIZE-1:0] NICE_PRED = 3'd0;
    localparam logic [FLUSH_CODE_SIZE-1:0] JMP_FLUSH = 3'd1;
    localparam logic [FLUSH_CODE_SIZE-1:0] BR_FLUSH  = 3'd2;
    localparam logic [FLUSH_CODE_SIZE-1:0] NBR_FLUSH = 3'd3;
    localparam logic [FLUSH_CODE_SIZE-1:0] JR_FLUSH  = 3'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_redirect_mux.sv
// Decodes the ID flush code into a redirect strobe and target PC; purely combinational.
// Zero latency, no backpressure; unused codes read as a correct prediction.
module fetch_redirect_mux
    import cpu_defs::*;
#(
    parameter int W = WORD_SIZE
) (
    input  logic [FLUSH_CODE_SIZE-1:0] flush_code_i,
    input  logic [W-1:0]               jmp_target_i,
    input  logic [W-1:0]               br_target_i,
    input  logic [W-1:0]               nbr_target_i,
    input  logic [W-1:0]               jr_target_i,
    output logic                       redirect_vld_o,
    output logic [W-1:0]               target_o
);
    always_comb begin
        redirect_vld_o = 1'b1;
        target_o       = '0;
        case (flush_code_i)
            JMP_FLUSH: target_o = jmp_target_i;
            BR_FLUSH:  target_o = br_target_i;
            NBR_FLUSH: target_o = nbr_target_i;
            JR_FLUSH:  target_o = jr_target_i;
            default:   redirect_vld_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: drives PC to BTB/I-cache, fills IF/ID; same-cycle hit gives 1 instr/cycle.
// ID stall parks one returned word in a skid (i_req drops); a flush during a miss drains the stale word.
module if_fetch_unit #(
    parameter int                   WORD_SIZE = cpu_defs::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 stall,
    input  logic [cpu_defs::FLUSH_CODE_SIZE-1:0] flush_code,
    input  logic [WORD_SIZE-1:0]                 jmp_target,
    input  logic [WORD_SIZE-1:0]                 br_target,
    input  logic [WORD_SIZE-1:0]                 fw_rf_read_data1,
    input  logic [WORD_SIZE-1:0]                 btb_pred,
    output logic [WORD_SIZE-1:0]                 pc,
    output logic                                 i_req,
    output logic [WORD_SIZE-1:0]                 i_addr,
    input  logic                                 i_ready,
    input  logic [WORD_SIZE-1:0]                 i_data,
    output logic [WORD_SIZE-1:0]                 instr_ID,
    output logic [WORD_SIZE-1:0]                 pc_1_ID,
    output logic [WORD_SIZE-1:0]                 pred_ID,
    output logic                                 valid_ID
);
    import cpu_defs::*;

    fetch_state_t         state_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] instr_q;
    logic [WORD_SIZE-1:0] pc1_q;
    logic [WORD_SIZE-1:0] pred_q;
    logic                 valid_q;
    logic [WORD_SIZE-1:0] skid_instr_q;
    logic [WORD_SIZE-1:0] skid_pc1_q;
    logic [WORD_SIZE-1:0] skid_pred_q;
    logic [WORD_SIZE-1:0] redir_q;
    logic [WORD_SIZE-1:0] redir_d;
    logic [WORD_SIZE-1:0] pc_plus1;
    logic                 redirect_vld;
    logic [WORD_SIZE-1:0] redirect_tgt;

    fetch_redirect_mux #(.W(WORD_SIZE)) u_redirect_mux (
        .flush_code_i   (flush_code),
        .jmp_target_i   (jmp_target),
        .br_target_i    (br_target),
        .nbr_target_i   (pc1_q),
        .jr_target_i    (fw_rf_read_data1),
        .redirect_vld_o (redirect_vld),
        .target_o       (redirect_tgt)
    );

    assign pc_plus1 = pc_q + WORD_SIZE'(1);
    // Newest flush wins while draining a stale fetch.
    assign redir_d  = redirect_vld ? redirect_tgt : redir_q;

    assign pc       = pc_q;
    assign i_addr   = pc_q;
    assign i_req    = ~reset & (state_q != ST_HOLD);
    assign instr_ID = instr_q;
    assign pc_1_ID  = pc1_q;
    assign pred_ID  = pred_q;
    assign valid_ID = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pc1_q        <= '0;
            pred_q       <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc1_q   <= '0;
            skid_pred_q  <= '0;
            redir_q      <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (redirect_vld) begin
                        valid_q <= 1'b0;
                        if (i_ready) begin
                            pc_q <= redirect_tgt;
                        end else begin
                            // Keep i_addr stable until the outstanding miss returns.
                            redir_q <= redirect_tgt;
                            state_q <= ST_DROP;
                        end
                    end else if (i_ready) begin
                        if (!stall) begin
                            instr_q <= i_data;
                            pc1_q   <= pc_plus1;
                            pred_q  <= btb_pred;
                            valid_q <= 1'b1;
                            pc_q    <= btb_pred;
                        end else begin
                            skid_instr_q <= i_data;
                            skid_pc1_q   <= pc_plus1;
                            skid_pred_q  <= btb_pred;
                            state_q      <= ST_HOLD;
                        end
                    end else if (!stall) begin
                        valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect_vld) begin
                        pc_q    <= redirect_tgt;
                        valid_q <= 1'b0;
                        state_q <= ST_FETCH;
                    end else if (!stall) begin
                        instr_q <= skid_instr_q;
                        pc1_q   <= skid_pc1_q;
                        pred_q  <= skid_pred_q;
                        valid_q <= 1'b1;
                        pc_q    <= skid_pred_q;
                        state_q <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    redir_q <= redir_d;
                    if (i_ready) begin
                        pc_q    <= redir_d;
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end
endmodule
